id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with load-use interlock for the 4-bit register-address, 32-bit datapath CPU. It captures decoded operands, register numbers and control from the decode stage and presents them to the execute stage and the ALU forwarding logic. It inserts bubbles when an instruction in execute is a load whose destination is a source of the instruction in decode. It squashes on a taken branch.

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use interlock.
//
// Captures decoded operands, register numbers and control from decode and
// presents them to execute and the forwarding logic. When the instruction in
// execute is a load whose destination is read by the decode instruction,
// bubbles are inserted for LOAD_STALL cycles while stall_o holds PC and IF/ID.
// A taken branch (flush_i) squashes the decode instruction.
//
// Parameters:
//   DW         operand data width
//   AW         register address width
//   LOAD_STALL bubbles per load-use hazard (1..3)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush_i                 squash decode instruction
//   id_*                    decode-stage instruction fields
//   ex_*                    registered copies for execute (all 0 = bubble)
//   stall_o                 hold PC and IF/ID this cycle (combinational)
//   stall_cnt_o             saturating stall-cycle count, present only when
//                           the ID_EX_PERF_EN macro is defined
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal advance; detects load-use hazards, first bubble cycle
// STALL | extra bubble cycles; cnt_q counts remaining cycles after this

module id_ex_stage #(
  parameter int DW         = 32,
  parameter int AW         = 4,
  parameter int LOAD_STALL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_r2_i,
  input  logic [AW-1:0] id_r3_i,
  input  logic          id_r2_use_i,
  input  logic          id_r3_use_i,
  input  logic [DW-1:0] id_r2res_i,
  input  logic [DW-1:0] id_r3res_i,
  input  logic [AW-1:0] id_dest_i,
  input  logic [1:0]    id_extnd_sel_i,
  input  logic [3:0]    id_alu_op_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  output logic          ex_valid_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic [AW-1:0] ex_r2_o,
  output logic [AW-1:0] ex_r3_o,
  output logic [AW-1:0] ex_dest_o,
  output logic [DW-1:0] ex_r2res_o,
  output logic [DW-1:0] ex_r3res_o,
  output logic [1:0]    ex_extnd_sel_o,
  output logic [3:0]    ex_alu_op_o,
  output logic          stall_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic [AW-1:0] r2;
    logic [AW-1:0] r3;
    logic [AW-1:0] dest;
    logic [DW-1:0] r2res;
    logic [DW-1:0] r3res;
    logic [1:0]    extnd_sel;
    logic [3:0]    alu_op;
  } ex_t;

  // Remaining STALL cycles after the hazard cycle itself, minus one.
  localparam logic [1:0] CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ex_t        ex_q, ex_d;
  logic       hz;

  // No zero-register exemption: every register number can carry a hazard.
  assign hz = id_valid_i & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
              ((id_r2_use_i & (id_r2_i == ex_q.dest)) |
               (id_r3_use_i & (id_r3_i == ex_q.dest)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = '0;
    stall_o = 1'b0;
    if (flush_i) begin
      state_d = RUN;
    end else if (state_q == STALL) begin
      stall_o = 1'b1;
      if (cnt_q == 2'd0) state_d = RUN;
      else               cnt_d   = cnt_q - 2'd1;
    end else if (hz) begin
      stall_o = 1'b1;
      if (LOAD_STALL > 1) begin
        cnt_d   = CNT_INIT;
        state_d = STALL;
      end
    end else if (id_valid_i) begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = id_reg_write_i;
      ex_d.mem_read  = id_mem_read_i;
      ex_d.r2        = id_r2_i;
      ex_d.r3        = id_r3_i;
      ex_d.dest      = id_dest_i;
      ex_d.r2res     = id_r2res_i;
      ex_d.r3res     = id_r3res_i;
      ex_d.extnd_sel = id_extnd_sel_i;
      ex_d.alu_op    = id_alu_op_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_reg_write_o = ex_q.reg_write;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_r2_o        = ex_q.r2;
  assign ex_r3_o        = ex_q.r3;
  assign ex_dest_o      = ex_q.dest;
  assign ex_r2res_o     = ex_q.r2res;
  assign ex_r3res_o     = ex_q.r3res;
  assign ex_extnd_sel_o = ex_q.extnd_sel;
  assign ex_alu_op_o    = ex_q.alu_op;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three instances with LOAD_STALL = 1, 2, 3 share the
// same decode-side stimulus; each instance's outputs are compared against
// hand-derived values. Perf-counter checks are built only with ID_EX_PERF_EN.

module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          id_valid_i;
  logic [AW-1:0] id_r2_i, id_r3_i, id_dest_i;
  logic          id_r2_use_i, id_r3_use_i;
  logic [DW-1:0] id_r2res_i, id_r3res_i;
  logic [1:0]    id_extnd_sel_i;
  logic [3:0]    id_alu_op_i;
  logic          id_reg_write_i, id_mem_read_i;

  logic          ex_valid [3];
  logic          ex_reg_write [3];
  logic          ex_mem_read [3];
  logic [AW-1:0] ex_r2 [3];
  logic [AW-1:0] ex_r3 [3];
  logic [AW-1:0] ex_dest [3];
  logic [DW-1:0] ex_r2res [3];
  logic [DW-1:0] ex_r3res [3];
  logic [1:0]    ex_extnd_sel [3];
  logic [3:0]    ex_alu_op [3];
  logic          stall [3];
`ifdef ID_EX_PERF_EN
  logic [31:0]   stall_cnt [3];
`endif

  int checks;
  int failures;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    id_ex_stage #(.DW(DW), .AW(AW), .LOAD_STALL(g + 1)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_i        (flush_i),
      .id_valid_i     (id_valid_i),
      .id_r2_i        (id_r2_i),
      .id_r3_i        (id_r3_i),
      .id_r2_use_i    (id_r2_use_i),
      .id_r3_use_i    (id_r3_use_i),
      .id_r2res_i     (id_r2res_i),
      .id_r3res_i     (id_r3res_i),
      .id_dest_i      (id_dest_i),
      .id_extnd_sel_i (id_extnd_sel_i),
      .id_alu_op_i    (id_alu_op_i),
      .id_reg_write_i (id_reg_write_i),
      .id_mem_read_i  (id_mem_read_i),
      .ex_valid_o     (ex_valid[g]),
      .ex_reg_write_o (ex_reg_write[g]),
      .ex_mem_read_o  (ex_mem_read[g]),
      .ex_r2_o        (ex_r2[g]),
      .ex_r3_o        (ex_r3[g]),
      .ex_dest_o      (ex_dest[g]),
      .ex_r2res_o     (ex_r2res[g]),
      .ex_r3res_o     (ex_r3res[g]),
      .ex_extnd_sel_o (ex_extnd_sel[g]),
      .ex_alu_op_o    (ex_alu_op[g]),
      .stall_o        (stall[g])
`ifdef ID_EX_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic e0, input logic e1, input logic e2);
    chk($sformatf("%s_stall_ls1", tag), 32'(stall[0]), 32'(e0));
    chk($sformatf("%s_stall_ls2", tag), 32'(stall[1]), 32'(e1));
    chk($sformatf("%s_stall_ls3", tag), 32'(stall[2]), 32'(e2));
  endtask

  // valid plus destination; a bubble must show dest=0 and reg_write=0 too
  task automatic chk_ex(input string tag, input int i, input logic v, input logic [AW-1:0] dest,
                        input logic rw);
    chk($sformatf("%s_valid_ls%0d", tag, i + 1), 32'(ex_valid[i]), 32'(v));
    chk($sformatf("%s_dest_ls%0d", tag, i + 1), 32'(ex_dest[i]), 32'(dest));
    chk($sformatf("%s_rw_ls%0d", tag, i + 1), 32'(ex_reg_write[i]), 32'(rw));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    flush_i = 1'b0; id_valid_i = 1'b0;
    id_r2_i = '0; id_r3_i = '0; id_r2_use_i = 1'b0; id_r3_use_i = 1'b0;
    id_r2res_i = '0; id_r3res_i = '0; id_dest_i = '0;
    id_extnd_sel_i = '0; id_alu_op_i = '0;
    id_reg_write_i = 1'b0; id_mem_read_i = 1'b0;
  endtask

  task automatic instr(input logic [AW-1:0] r2, input logic r2u, input logic [AW-1:0] r3,
                       input logic r3u, input logic [AW-1:0] dest, input logic mr);
    id_valid_i = 1'b1;
    id_r2_i = r2; id_r2_use_i = r2u;
    id_r3_i = r3; id_r3_use_i = r3u;
    id_dest_i = dest;
    id_r2res_i = 32'h0000_1000 + 32'(dest);
    id_r3res_i = 32'h0000_2000 + 32'(dest);
    id_extnd_sel_i = 2'b01;
    id_alu_op_i = 4'(dest);
    id_reg_write_i = 1'b1;
    id_mem_read_i = mr;
  endtask

`ifdef ID_EX_PERF_EN
  // load to r4, then a dependent instruction held until every instance is through
  task automatic do_hazard;
    instr(4'd1, 1'b0, 4'd1, 1'b0, 4'd4, 1'b1);
    tick;
    instr(4'd4, 1'b1, 4'd0, 1'b0, 4'd12, 1'b0);
    repeat (4) tick;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    idle_in;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_ex("reset", i, 1'b0, 4'd0, 1'b0);
    chk_stall("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // plain advance
    instr(4'd3, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0);
    id_r2res_i = 32'h0000_1234;
    id_extnd_sel_i = 2'b10;
    id_alu_op_i = 4'h6;
    #1 chk_stall("adv", 1'b0, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk_ex("adv", i, 1'b1, 4'd5, 1'b1);
      chk($sformatf("adv_r2_ls%0d", i + 1), 32'(ex_r2[i]), 32'd3);
      chk($sformatf("adv_r2res_ls%0d", i + 1), ex_r2res[i], 32'h0000_1234);
      chk($sformatf("adv_alu_ls%0d", i + 1), 32'(ex_alu_op[i]), 32'h6);
      chk($sformatf("adv_ext_ls%0d", i + 1), 32'(ex_extnd_sel[i]), 32'h2);
    end
    chk_stall("adv_after", 1'b0, 1'b0, 1'b0);

    // load to r4 enters EX
    instr(4'd1, 1'b0, 4'd2, 1'b0, 4'd4, 1'b1);
    tick;
    chk("load_mr_ls1", 32'(ex_mem_read[0]), 32'd1);

    // decode reads r4 through r3 but does not use it: no stall
    instr(4'd7, 1'b1, 4'd4, 1'b0, 4'd6, 1'b0);
    #1 chk_stall("unused", 1'b0, 1'b0, 1'b0);
    // same instruction now using r3: hazard in every instance
    id_r3_use_i = 1'b1;
    #1 chk_stall("hz_r3", 1'b1, 1'b1, 1'b1);
    tick;
    for (int i = 0; i < 3; i++) chk_ex("hz_e1", i, 1'b0, 4'd0, 1'b0);
    chk_stall("hz_e1", 1'b0, 1'b1, 1'b1);
    tick;
    chk_ex("hz_e2", 0, 1'b1, 4'd6, 1'b1);
    chk("hz_e2_r3_ls1", 32'(ex_r3[0]), 32'd4);
    chk("hz_e2_r3res_ls1", ex_r3res[0], 32'h0000_2006);
    chk_ex("hz_e2", 1, 1'b0, 4'd0, 1'b0);
    chk_ex("hz_e2", 2, 1'b0, 4'd0, 1'b0);
    chk_stall("hz_e2", 1'b0, 1'b0, 1'b1);
    tick;
    chk_ex("hz_e3", 1, 1'b1, 4'd6, 1'b1);
    chk_ex("hz_e3", 2, 1'b0, 4'd0, 1'b0);
    chk_stall("hz_e3", 1'b0, 1'b0, 1'b0);
    tick;
    chk_ex("hz_e4", 2, 1'b1, 4'd6, 1'b1);
`ifdef ID_EX_PERF_EN
    chk("perf_hz_ls1", stall_cnt[0], 32'd1);
    chk("perf_hz_ls2", stall_cnt[1], 32'd2);
    chk("perf_hz_ls3", stall_cnt[2], 32'd3);
`endif

    // hazard through r2, then flush on the second stall cycle
    instr(4'd1, 1'b0, 4'd1, 1'b0, 4'd4, 1'b1);
    tick;
    instr(4'd4, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0);
    #1 chk_stall("fl_hz", 1'b1, 1'b1, 1'b1);
    tick;
    for (int i = 0; i < 3; i++) chk_ex("fl_e1", i, 1'b0, 4'd0, 1'b0);
    flush_i = 1'b1;
    #1 chk_stall("fl_on", 1'b0, 1'b0, 1'b0);
    tick;
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) chk_ex("fl_e2", i, 1'b0, 4'd0, 1'b0);
    instr(4'd4, 1'b1, 4'd0, 1'b0, 4'd10, 1'b0);
    #1 chk_stall("fl_run", 1'b0, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) chk_ex("fl_next", i, 1'b1, 4'd10, 1'b1);

    // reset in the middle of a stall
    instr(4'd1, 1'b0, 4'd1, 1'b0, 4'd4, 1'b1);
    tick;
    instr(4'd0, 1'b0, 4'd4, 1'b1, 4'd8, 1'b0);
    #1 chk_stall("rs_hz", 1'b1, 1'b1, 1'b1);
    tick;
    #2;
    rst_n = 1'b0;
    idle_in;
    #1;
    for (int i = 0; i < 3; i++) chk_ex("rs_mid", i, 1'b0, 4'd0, 1'b0);
    chk_stall("rs_mid", 1'b0, 1'b0, 1'b0);
`ifdef ID_EX_PERF_EN
    chk("perf_rst_ls3", stall_cnt[2], 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    instr(4'd4, 1'b1, 4'd4, 1'b1, 4'd11, 1'b0);
    #1 chk_stall("rs_after", 1'b0, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) chk_ex("rs_adv", i, 1'b1, 4'd11, 1'b1);

    // a load that does not write the register file is not a hazard source
    id_reg_write_i = 1'b0;
    id_mem_read_i = 1'b1;
    id_dest_i = 4'd4;
    tick;
    instr(4'd4, 1'b1, 4'd0, 1'b0, 4'd13, 1'b0);
    #1 chk_stall("nowr_load", 1'b0, 1'b0, 1'b0);
    tick;

`ifdef ID_EX_PERF_EN
    rst_n = 1'b0;
    idle_in;
    #1;
    rst_n = 1'b1;
    do_hazard;
    do_hazard;
    chk("perf_two_ls2", stall_cnt[1], 32'd4);
    chk("perf_two_ls3", stall_cnt[2], 32'd6);
    force gen_dut[1].u_dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release gen_dut[1].u_dut.stall_cnt_q;
    do_hazard;
    chk("perf_sat_ls2", stall_cnt[1], 32'hFFFF_FFFF);
`endif

    idle_in;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
